// File: rtl/frame_writer_pkg.sv
// Shared types and AXI constants for the frame memory writer.
package frame_writer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_ISSUE,
        ST_DRAIN,
        ST_WAIT_RESP,
        ST_FRAME_DONE
    } state_e;

    localparam logic [2:0]  AXI_SIZE_4B     = 3'b010;
    localparam logic [1:0]  AXI_BURST_INCR  = 2'b01;
    localparam int unsigned BYTES_PER_PIXEL = 4;

endpackage

// File: rtl/frame_memory_writer_if.sv
// Video stream input, burst command/data pull and frame status bundle.
// master: the frame writer; slave: the stream source plus AXI burst master.
interface frame_memory_writer_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic [DATA_WIDTH-1:0]   s_axis_tdata;
    logic                    s_axis_tvalid;
    logic                    s_axis_tready;
    logic                    s_axis_tlast;
    logic                    s_axis_tuser;
    logic [31:0]             pixels_per_frame;
    logic [15:0]             frame_height;
    logic                    start_write;
    logic [ADDR_WIDTH-1:0]   write_addr;
    logic [31:0]             write_len;
    logic [2:0]              write_size;
    logic [1:0]              write_burst;
    logic [DATA_WIDTH-1:0]   write_data;
    logic [DATA_WIDTH/8-1:0] write_strb;
    logic                    write_data_req;
    logic                    write_done;
    logic                    frame_ready;
    logic [ADDR_WIDTH-1:0]   base_addr_out;

    modport master (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        input  pixels_per_frame, frame_height, write_data_req, write_done,
        output s_axis_tready, start_write, write_addr, write_len, write_size,
        output write_burst, write_data, write_strb, frame_ready, base_addr_out
    );

    modport slave (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        output pixels_per_frame, frame_height, write_data_req, write_done,
        input  s_axis_tready, start_write, write_addr, write_len, write_size,
        input  write_burst, write_data, write_strb, frame_ready, base_addr_out
    );

endinterface

// File: rtl/frame_memory_writer_line_fifo.sv
// Single-clock line buffer; flush with a simultaneous push restarts it holding that one word.
module line_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 256
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push_i,
    input  logic                           pop_i,
    input  logic                           flush_i,
    input  logic [DATA_WIDTH-1:0]          wr_data_i,
    output logic [DATA_WIDTH-1:0]          rd_data_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH):0]         count_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  do_push;
    logic                  do_pop;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign do_push   = push_i && (flush_i || !full_o);
    assign do_pop    = pop_i && !empty_o && !flush_i;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[flush_i ? '0 : wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= do_push ? PTR_W'(1) : '0;
            rd_ptr_q <= '0;
            count_q  <= do_push ? CNT_W'(1) : '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
            else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/frame_memory_writer.sv
// Buffers a video frame line by line and issues one INCR burst per line.
// Optional FRAME_PINGPONG_EN alternates frames between BASE_ADDR0 and BASE_ADDR1.
module frame_memory_writer
    import frame_writer_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           LINE_DEPTH = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR0 = '0,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR1 = ADDR_WIDTH'(32'h0400)
) (
    input logic                   clk,
    input logic                   rst,
    frame_memory_writer_if.master bus
);
    localparam int unsigned CNT_W = $clog2(LINE_DEPTH) + 1;

    state_e                  state_q;
    logic                    tready_q;
    logic                    start_write_q;
    logic                    frame_ready_q;
    logic [ADDR_WIDTH-1:0]   write_addr_q;
    logic [31:0]             write_len_q;
    logic [ADDR_WIDTH-1:0]   base_addr_out_q;
    logic [ADDR_WIDTH-1:0]   line_offset_q;
    logic [31:0]             pixel_cnt_q;
    logic [15:0]             line_cnt_q;
    logic [31:0]             ppf_q;
    logic [15:0]             height_q;
    logic [CNT_W-1:0]        beats_q;

    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CNT_W-1:0]        fifo_count;
    logic [DATA_WIDTH-1:0]   fifo_rd_data;

    logic                    accept_c;
    logic                    restart_c;
    logic [CNT_W-1:0]        fill_c;
    logic [31:0]             ppf_eff_c;
    logic [31:0]             pix_base_c;
    logic [ADDR_WIDTH-1:0]   offset_base_c;
    logic                    line_end_c;
    logic [ADDR_WIDTH-1:0]   frame_base_c;
    logic [ADDR_WIDTH-1:0]   line_offset_d;
    logic [31:0]             pixel_cnt_d;
    logic [15:0]             line_cnt_d;
    logic                    frame_end_c;

`ifdef FRAME_PINGPONG_EN
    logic buf_sel_q;
    assign frame_base_c = buf_sel_q ? BASE_ADDR1 : BASE_ADDR0;
`else
    assign frame_base_c = BASE_ADDR0;
`endif

    // A tuser beat (in IDLE or mid-frame) restarts the frame with that beat as pixel 0
    assign accept_c  = bus.s_axis_tvalid && tready_q;
    assign restart_c = accept_c && bus.s_axis_tuser &&
                       ((state_q == ST_IDLE) || (state_q == ST_FILL));
    assign fifo_push = accept_c && (restart_c || ((state_q == ST_FILL) && !fifo_full));
    assign fifo_pop  = (state_q == ST_DRAIN) && bus.write_data_req;

    assign fill_c        = restart_c ? CNT_W'(1) : fifo_count + CNT_W'(1);
    assign ppf_eff_c     = restart_c ? bus.pixels_per_frame : ppf_q;
    assign pix_base_c    = restart_c ? '0 : pixel_cnt_q;
    assign offset_base_c = restart_c ? '0 : line_offset_q;

    // Close the line on tlast, a full buffer, or the frame's last pixel
    assign line_end_c = bus.s_axis_tlast || (fill_c == CNT_W'(LINE_DEPTH)) ||
                        (({1'b0, pix_base_c} + 33'(fill_c)) >= {1'b0, ppf_eff_c});

    assign line_offset_d = line_offset_q + ADDR_WIDTH'(beats_q) * ADDR_WIDTH'(BYTES_PER_PIXEL);
    assign pixel_cnt_d   = pixel_cnt_q + 32'(beats_q);
    assign line_cnt_d    = line_cnt_q + 16'd1;
    assign frame_end_c   = (pixel_cnt_d >= ppf_q) || (line_cnt_d == height_q);

    line_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (LINE_DEPTH)
    ) u_line_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (fifo_push),
        .pop_i     (fifo_pop),
        .flush_i   (restart_c),
        .wr_data_i (bus.s_axis_tdata),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            tready_q        <= 1'b0;
            start_write_q   <= 1'b0;
            frame_ready_q   <= 1'b0;
            write_addr_q    <= '0;
            write_len_q     <= '0;
            base_addr_out_q <= BASE_ADDR0;
            line_offset_q   <= '0;
            pixel_cnt_q     <= '0;
            line_cnt_q      <= '0;
            ppf_q           <= '0;
            height_q        <= '0;
            beats_q         <= '0;
`ifdef FRAME_PINGPONG_EN
            buf_sel_q       <= 1'b0;
`endif
        end else begin
            start_write_q <= 1'b0;
            frame_ready_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_FILL: begin
                    tready_q <= 1'b1;
                    if (restart_c) begin
                        ppf_q         <= bus.pixels_per_frame;
                        height_q      <= bus.frame_height;
                        pixel_cnt_q   <= '0;
                        line_cnt_q    <= '0;
                        line_offset_q <= '0;
                    end
                    if (fifo_push && line_end_c) begin
                        state_q       <= ST_ISSUE;
                        tready_q      <= 1'b0;
                        start_write_q <= 1'b1;
                        write_addr_q  <= frame_base_c + offset_base_c;
                        write_len_q   <= 32'(fill_c) - 32'd1;
                        beats_q       <= fill_c;
                    end else if (restart_c) begin
                        state_q <= ST_FILL;
                    end
                end
                ST_ISSUE: state_q <= ST_DRAIN;
                ST_DRAIN: begin
                    if (fifo_empty || (fifo_pop && (fifo_count == CNT_W'(1)))) begin
                        state_q <= ST_WAIT_RESP;
                    end
                end
                ST_WAIT_RESP: begin
                    if (bus.write_done) begin
                        line_offset_q <= line_offset_d;
                        pixel_cnt_q   <= pixel_cnt_d;
                        line_cnt_q    <= line_cnt_d;
                        if (frame_end_c) begin
                            state_q         <= ST_FRAME_DONE;
                            frame_ready_q   <= 1'b1;
                            base_addr_out_q <= frame_base_c;
`ifdef FRAME_PINGPONG_EN
                            buf_sel_q       <= !buf_sel_q;
`endif
                        end else begin
                            state_q  <= ST_FILL;
                            tready_q <= 1'b1;
                        end
                    end
                end
                ST_FRAME_DONE: begin
                    state_q  <= ST_IDLE;
                    tready_q <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.s_axis_tready = tready_q;
    assign bus.start_write   = start_write_q;
    assign bus.write_addr    = write_addr_q;
    assign bus.write_len     = write_len_q;
    assign bus.write_size    = AXI_SIZE_4B;
    assign bus.write_burst   = AXI_BURST_INCR;
    assign bus.write_data    = fifo_rd_data;
    assign bus.write_strb    = '1;
    assign bus.frame_ready   = frame_ready_q;
    assign bus.base_addr_out = base_addr_out_q;

endmodule

// File: tb/tb_frame_memory_writer.sv
// Directed and randomized frames against a line/frame-level reference model.
module tb_frame_memory_writer;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE0 = 32'h0000_0000;
    localparam logic [31:0] BASE1 = 32'h0000_0400;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    frame_memory_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

    frame_memory_writer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int checks      = 0;
    int failures    = 0;
    int frames_seen = 0;
    int frames_exp  = 0;
    int stall_line  = -1;
    int abort_at    = -1;

    // Reference model: the current frame's progress and the line being collected
    int          m_ppf;
    int          m_h;
    int          m_pix;
    int          m_lines;
    logic [31:0] m_off;
    bit          m_active = 1'b0;
    bit          m_buf    = 1'b0;
    logic [31:0] m_q[$];

    always @(negedge clk) if (bus_if.frame_ready === 1'b1) frames_seen <= frames_seen + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_base();
        return m_buf ? BASE1 : BASE0;
    endfunction

    task automatic check_reset_outputs();
        check("rst_tready", 64'(bus_if.s_axis_tready), 64'd0);
        check("rst_start_write", 64'(bus_if.start_write), 64'd0);
        check("rst_write_addr", 64'(bus_if.write_addr), 64'd0);
        check("rst_write_len", 64'(bus_if.write_len), 64'd0);
        check("rst_frame_ready", 64'(bus_if.frame_ready), 64'd0);
        check("rst_base_addr_out", 64'(bus_if.base_addr_out), 64'(BASE0));
    endtask

    // Collect one burst: command, ordered data pull, response, frame status
    task automatic service();
        int          nb;
        int          n;
        bit          fdone;
        bit          aborted;
        logic [31:0] exp_addr;
        nb       = m_q.size();
        exp_addr = m_base() + m_off;
        aborted  = 1'b0;
        n = 0;
        while (bus_if.start_write !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("start_write", 64'(bus_if.start_write), 64'd1);
        check("write_addr", 64'(bus_if.write_addr), 64'(exp_addr));
        check("write_len", 64'(bus_if.write_len), 64'(nb - 1));
        check("size_burst_strb", 64'({bus_if.write_size, bus_if.write_burst, bus_if.write_strb}),
              64'({3'b010, 2'b01, 4'hf}));
        @(negedge clk);
        check("start_write_pulse", 64'(bus_if.start_write), 64'd0);
        for (int i = 0; i < nb && !aborted; i++) begin
            if (i == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                check_reset_outputs();
                bus_if.write_data_req = 1'b0;
                rst = 1'b0;
                @(negedge clk);
                m_active = 1'b0;
                m_buf    = 1'b0;
                m_q.delete();
                abort_at = -1;
                aborted  = 1'b1;
            end else begin
                if (m_lines == stall_line && i == 0) begin
                    repeat (20) @(negedge clk);
                    check("bp_tready", 64'(bus_if.s_axis_tready), 64'd0);
                    check("bp_write_data", 64'(bus_if.write_data), 64'(m_q[0]));
                end
                repeat ($urandom_range(0, 2)) @(negedge clk);
                check("write_data", 64'(bus_if.write_data), 64'(m_q[i]));
                bus_if.write_data_req = 1'b1;
                @(posedge clk);
                @(negedge clk);
                bus_if.write_data_req = 1'b0;
            end
        end
        if (!aborted) begin
            check("write_addr_hold", 64'(bus_if.write_addr), 64'(exp_addr));
            check("tready_wait_resp", 64'(bus_if.s_axis_tready), 64'd0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            bus_if.write_done = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus_if.write_done = 1'b0;
            m_off   = m_off + 32'(4 * nb);
            m_pix   = m_pix + nb;
            m_lines = m_lines + 1;
            m_q.delete();
            fdone = (m_pix >= m_ppf) || (m_lines == m_h);
            check("frame_ready", 64'(bus_if.frame_ready), 64'(fdone));
            if (fdone) begin
                check("base_addr_out", 64'(bus_if.base_addr_out), 64'(m_base()));
                frames_exp++;
                m_active = 1'b0;
`ifdef FRAME_PINGPONG_EN
                m_buf = !m_buf;
`endif
                @(negedge clk);
                check("frame_ready_pulse", 64'(bus_if.frame_ready), 64'd0);
            end
        end
    endtask

    // Offer one beat, then let the model decide whether a burst is now due
    task automatic beat(input logic [31:0] d, input bit u, input bit l);
        int n;
        bus_if.s_axis_tdata  = d;
        bus_if.s_axis_tuser  = u;
        bus_if.s_axis_tlast  = l;
        bus_if.s_axis_tvalid = 1'b1;
        n = 0;
        while (bus_if.s_axis_tready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("tready_timeout", 64'(bus_if.s_axis_tready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus_if.s_axis_tvalid = 1'b0;
        bus_if.s_axis_tuser  = 1'b0;
        bus_if.s_axis_tlast  = 1'b0;
        if (m_active || u) begin
            if (u) begin
                m_active = 1'b1;
                m_q.delete();
                m_ppf   = int'(bus_if.pixels_per_frame);
                m_h     = int'(bus_if.frame_height);
                m_pix   = 0;
                m_lines = 0;
                m_off   = '0;
            end
            m_q.push_back(d);
            if (l || m_q.size() == DEPTH || (m_pix + m_q.size()) >= m_ppf) service();
        end
    endtask

    initial begin
        logic [7:0] p8;
        int         k;
        bus_if.s_axis_tdata     = '0;
        bus_if.s_axis_tvalid    = 1'b0;
        bus_if.s_axis_tlast     = 1'b0;
        bus_if.s_axis_tuser     = 1'b0;
        bus_if.pixels_per_frame = 32'd256;
        bus_if.frame_height     = 16'd16;
        bus_if.write_data_req   = 1'b0;
        bus_if.write_done       = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        @(negedge clk);

        // Beats before any tuser are dropped
        repeat (3) beat($urandom, 1'b0, 1'($urandom_range(0, 1)));

        // 16x16 pattern frame, 20-cycle pull stall on line 2
        stall_line = 2;
        for (int p = 0; p < 256; p++) begin
            p8 = 8'(p);
            beat({8'h00, p8, p8, p8}, p == 0, (p % 16) == 15);
        end
        stall_line = -1;

        // Second 16x16 frame, random pixels
        for (int p = 0; p < 256; p++) beat($urandom, p == 0, (p % 16) == 15);

        // 300 beats without tlast
        bus_if.pixels_per_frame = 32'd300;
        for (int p = 0; p < 300; p++) beat($urandom, p == 0, 1'b0);

        // Mid-line tuser restarts the frame
        bus_if.pixels_per_frame = 32'd64;
        bus_if.frame_height     = 16'd4;
        for (int p = 0; p < 5; p++) beat($urandom, p == 0, 1'b0);
        for (int p = 0; p < 64; p++) beat($urandom, p == 0, (p % 16) == 15);

        // Random line lengths, ended by pixel count or line count
        bus_if.pixels_per_frame = 32'd100;
        bus_if.frame_height     = 16'd8;
        k = 0;
        beat($urandom, 1'b1, $urandom_range(0, 5) == 0);
        while (m_active && k < 400) begin
            beat($urandom, 1'b0, $urandom_range(0, 5) == 0);
            k++;
        end

        // Reset in the middle of a drain, then a clean frame
        bus_if.pixels_per_frame = 32'd32;
        bus_if.frame_height     = 16'd4;
        abort_at = 3;
        for (int p = 0; p < 8; p++) beat($urandom, p == 0, p == 7);
        for (int p = 0; p < 32; p++) beat($urandom, p == 0, (p % 8) == 7);

        repeat (3) @(negedge clk);
        check("frame_count", 64'(frames_seen), 64'(frames_exp));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
